// File: rtl/cnn_dot_mac_seq.sv
// ============================================================================
//  Module   : cnn_dot_mac_seq
//  Brief    : Dot-product sequencer for one shared 14s x 8s multiplier; reads
//             activations/weights from 1-cycle memories, accumulates products.
//             Optional macro CNN_MAC_SAT_EN selects a saturating accumulate.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cnn_dot_mac_seq #(
    parameter int MAX_LEN = 1024,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 11,
    parameter int ACC_W   = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] x_address0,
    output logic              x_ce0,
    input  logic [13:0]       x_q0,
    output logic [ADDR_W-1:0] w_address0,
    output logic              w_ce0,
    input  logic [7:0]        w_q0,
    output logic [13:0]       mul_a,
    output logic [7:0]        mul_b,
    input  logic [21:0]       mul_p,
    output logic [ACC_W-1:0]  ap_return
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LEN_W-1:0]  n_q;
    logic [ADDR_W-1:0] k_q;
    logic              drain_q;
    logic              v1_q;
    logic              v2_q;
    logic              v3_q;
    logic [13:0]       mul_a_q;
    logic [7:0]        mul_b_q;
    logic [21:0]       prod_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  ret_q;

    logic [LEN_W-1:0]  len_clamped;
    logic              last_issue;
    logic              start_job;
    logic [ACC_W-1:0]  acc_sum;

    assign len_clamped = (len > MAX_LEN_C) ? MAX_LEN_C : len;
    assign last_issue  = (LEN_W'(k_q) == (n_q - LEN_W'(1)));
    assign start_job   = (state_q == S_IDLE) && ap_start;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = (len_clamped == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        ap_idle    = (state_q == S_IDLE);
        ap_done    = (state_q == S_DONE);
        x_ce0      = (state_q == S_ISSUE);
        w_ce0      = (state_q == S_ISSUE);
        ap_ready   = (state_q == S_ISSUE) && last_issue;
        x_address0 = k_q;
        w_address0 = k_q;
        mul_a      = mul_a_q;
        mul_b      = mul_b_q;
        // The last term lands in the accumulator during DONE, so the result is
        // presented from the accumulate path then and held in ret_q afterwards.
        ap_return  = (state_q == S_DONE) ? acc_d : ret_q;
    end

    // ------------------------------------------------------------------
    // Accumulate arithmetic
    // ------------------------------------------------------------------
`ifdef CNN_MAC_SAT_EN
    localparam int               SUM_W   = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [SUM_W-1:0] sum_wide;

    assign sum_wide = SUM_W'($signed(acc_q)) + SUM_W'($signed(prod_q));

    always_comb begin
        acc_sum = sum_wide[ACC_W-1:0];
        if (sum_wide[SUM_W-1] != sum_wide[SUM_W-2]) begin
            acc_sum = sum_wide[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign acc_sum = acc_q + ACC_W'($signed(prod_q));
`endif

    assign acc_d = v3_q ? acc_sum : acc_q;

    // ------------------------------------------------------------------
    // Counters, operand pipeline and accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            n_q     <= '0;
            k_q     <= '0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            ret_q   <= '0;
        end else begin
            if (start_job) begin
                n_q <= len_clamped;
            end

            if (state_q == S_ISSUE) begin
                k_q <= last_issue ? '0 : (k_q + ADDR_W'(1));
            end

            drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;

            // Valid tag follows each term; operands fall back to zero when idle.
            v1_q    <= (state_q == S_ISSUE);
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            mul_a_q <= v1_q ? x_q0 : '0;
            mul_b_q <= v1_q ? w_q0 : '0;
            prod_q  <= v2_q ? mul_p : '0;

            if (start_job) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end

            if (state_q == S_DONE) begin
                ret_q <= acc_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnn_dot_mac_seq.sv
// Testbench for cnn_dot_mac_seq: table-driven dot products on a 32-bit and a
// 22-bit accumulator instance, plus held-start and mid-job reset sequences.
`default_nettype none

module tb_cnn_dot_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ap_start = 1'b0;
    logic [10:0] len = '0;

    logic ap_done_a, ap_idle_a, ap_ready_a, x_ce0_a, w_ce0_a;
    logic [9:0] x_address0_a, w_address0_a;
    logic [13:0] x_q0_a, mul_a_a;
    logic [7:0] w_q0_a, mul_b_a;
    logic [21:0] mul_p_a;
    logic [31:0] ap_return_a;

    logic ap_done_b, ap_idle_b, ap_ready_b, x_ce0_b, w_ce0_b;
    logic [9:0] x_address0_b, w_address0_b;
    logic [13:0] x_q0_b, mul_a_b;
    logic [7:0] w_q0_b, mul_b_b;
    logic [21:0] mul_p_b;
    logic [21:0] ap_return_b;

    logic [13:0] x_mem [1024];
    logic [7:0]  w_mem [1024];

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    cnn_dot_mac_seq #(.MAX_LEN(1024), .ADDR_W(10), .LEN_W(11), .ACC_W(32)) u_dut32 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start),
        .ap_done(ap_done_a), .ap_idle(ap_idle_a), .ap_ready(ap_ready_a),
        .len(len),
        .x_address0(x_address0_a), .x_ce0(x_ce0_a), .x_q0(x_q0_a),
        .w_address0(w_address0_a), .w_ce0(w_ce0_a), .w_q0(w_q0_a),
        .mul_a(mul_a_a), .mul_b(mul_b_a), .mul_p(mul_p_a),
        .ap_return(ap_return_a)
    );

    cnn_dot_mac_seq #(.MAX_LEN(1024), .ADDR_W(10), .LEN_W(11), .ACC_W(22)) u_dut22 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start),
        .ap_done(ap_done_b), .ap_idle(ap_idle_b), .ap_ready(ap_ready_b),
        .len(len),
        .x_address0(x_address0_b), .x_ce0(x_ce0_b), .x_q0(x_q0_b),
        .w_address0(w_address0_b), .w_ce0(w_ce0_b), .w_q0(w_q0_b),
        .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_p(mul_p_b),
        .ap_return(ap_return_b)
    );

    always @(posedge clk) begin
        if (x_ce0_a) x_q0_a <= x_mem[x_address0_a];
        if (w_ce0_a) w_q0_a <= w_mem[w_address0_a];
        if (x_ce0_b) x_q0_b <= x_mem[x_address0_b];
        if (w_ce0_b) w_q0_b <= w_mem[w_address0_b];
    end

    assign mul_p_a = 22'($signed(mul_a_a) * $signed(mul_b_a));
    assign mul_p_b = 22'($signed(mul_a_b) * $signed(mul_b_b));

    typedef struct {
        int len;
        int x0, x1, x2, x3, xf;
        int w0, w1, w2, w3, wf;
        int exp32;
        int exp22w;
        int exp22s;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp22(input vec_t v);
`ifdef CNN_MAC_SAT_EN
        return v.exp22s;
`else
        return v.exp22w;
`endif
    endfunction

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 1024; i++) begin
            x_mem[i] = 14'(v.xf);
            w_mem[i] = 8'(v.wf);
        end
        x_mem[0] = 14'(v.x0); x_mem[1] = 14'(v.x1); x_mem[2] = 14'(v.x2); x_mem[3] = 14'(v.x3);
        w_mem[0] = 8'(v.w0);  w_mem[1] = 8'(v.w1);  w_mem[2] = 8'(v.w2);  w_mem[3] = 8'(v.w3);
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int n, cyc, done_a, done_b, ready_cyc, ready_cnt, ce_cnt, last_addr, addr_bad;
        longint r32, r22;
        n = (v.len > 1024) ? 1024 : v.len;
        load_mem(v);
        @(negedge clk);
        len = 11'(v.len);
        ap_start = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
        cyc = 0; done_a = -1; done_b = -1; ready_cyc = -1; ready_cnt = 0;
        ce_cnt = 0; last_addr = -1; addr_bad = 0; r32 = 0; r22 = 0;
        while (done_a < 0 && cyc < 1100) begin
            @(negedge clk);
            cyc++;
            if (x_ce0_a) begin
                ce_cnt++;
                last_addr = int'(x_address0_a);
                if (!w_ce0_a || (w_address0_a != x_address0_a)) addr_bad++;
            end
            if (ap_ready_a) begin
                ready_cnt++;
                ready_cyc = cyc;
            end
            if (ap_done_b) begin
                done_b = cyc;
                r22 = longint'($signed(ap_return_b));
            end
            if (ap_done_a) begin
                done_a = cyc;
                r32 = longint'($signed(ap_return_a));
            end
        end
        chk({tag, " done_cycle"}, done_a, (n == 0) ? 1 : n + 3);
        chk({tag, " ret32"}, r32, v.exp32);
        chk({tag, " ret22"}, r22, exp22(v));
        chk({tag, " done22_cycle"}, done_b, done_a);
        chk({tag, " ready_cycle"}, ready_cyc, (n == 0) ? -1 : n);
        chk({tag, " ready_count"}, ready_cnt, (n == 0) ? 0 : 1);
        chk({tag, " reads"}, ce_cnt, n);
        chk({tag, " last_addr"}, last_addr, n - 1);
        chk({tag, " addr_pair"}, addr_bad, 0);
        @(negedge clk);
        chk({tag, " ret_hold"}, longint'($signed(ap_return_a)), v.exp32);
        chk({tag, " idle_after"}, ap_idle_a, 1);
    endtask

    initial begin
        int dones, cyc;
        int dcyc [2];
        longint dret [2];

        //          len   x0     x1     x2     x3    xf      w0    w1    w2    w3    wf    exp32        22 wrap   22 sat
        vt[0] = '{4,    1,     2,     3,     4,    0,      5,    6,    7,    8,    0,    70,          70,       70};
        vt[1] = '{1024, -8192, -8192, -8192, -8192, -8192, -128, -128, -128, -128, -128, 1073741824,  0,        2097151};
        vt[2] = '{0,    9,     9,     9,     9,    9,      9,    9,    9,    9,    9,    0,           0,        0};
        vt[3] = '{2000, 1,     1,     1,     1,    1,      1,    1,    1,    1,    1,    1024,        1024,     1024};
        vt[4] = '{4,    8191,  8191,  8191,  8191, 8191,   127,  127,  127,  127,  127,  4161028,     -33276,   2097151};
        vt[5] = '{3,    -3,    100,   8191,  0,    0,      7,    -2,   -128, 0,    0,    -1048669,    -1048669, -1048669};
        vt[6] = '{1,    -8192, 0,     0,     0,    0,      127,  0,    0,    0,    0,    -1040384,    -1040384, -1040384};
        vt[7] = '{4,    -8192, -8192, -8192, -8192, -8192, 127,  127,  127,  127,  127,  -4161536,    32768,    -2097152};
        vt[8] = '{4,    -8192, -8192, -8192, 8191, 0,      127,  127,  127,  127,  0,    -2080895,    -2080895, -1056895};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst idle", ap_idle_a, 1);
        chk("rst done", ap_done_a, 0);
        chk("rst ready", ap_ready_a, 0);
        chk("rst ce", {x_ce0_a, w_ce0_a}, 0);
        chk("rst addr", {x_address0_a, w_address0_a}, 0);
        chk("rst mul_ops", {mul_a_a, mul_b_a}, 0);
        chk("rst ret", ap_return_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst idle", ap_idle_a, 1);

        for (int i = 0; i < 9; i++) begin
            run_vector(vt[i], $sformatf("V%0d", i));
        end

        // ap_start held high: DONE ignores it, next job begins on the following IDLE cycle
        load_mem(vt[0]);
        @(negedge clk);
        len = 11'd4;
        ap_start = 1'b1;
        @(posedge clk);
        dones = 0; cyc = 0;
        dcyc[0] = -1; dcyc[1] = -1; dret[0] = 0; dret[1] = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 14) ap_start = 1'b0;
            if (ap_done_a) begin
                if (dones < 2) begin
                    dcyc[dones] = cyc;
                    dret[dones] = longint'($signed(ap_return_a));
                end
                dones++;
            end
        end
        chk("held done_count", dones, 2);
        chk("held done1_cycle", dcyc[0], 7);
        chk("held done2_cycle", dcyc[1], 15);
        chk("held ret1", dret[0], 70);
        chk("held ret2", dret[1], 70);

        // Asynchronous reset in the middle of ISSUE
        load_mem(vt[3]);
        @(negedge clk);
        len = 11'd8;
        ap_start = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort pre ce", x_ce0_a, 1);
        chk("abort pre ret", longint'($signed(ap_return_a)), 70);
        #1 rst = 1'b1;
        #1;
        chk("abort idle", ap_idle_a, 1);
        chk("abort ce", {x_ce0_a, w_ce0_a}, 0);
        chk("abort ret", ap_return_a, 0);
        chk("abort ret22", ap_return_b, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ap_done_a || ap_done_b) dones++;
        end
        chk("abort no_done", dones, 0);
        chk("abort ret_after", ap_return_a, 0);

        run_vector(vt[0], "AFTER_RST");
        run_vector(vt[8], "AFTER_RST_SAT");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
